// File: rtl/regfile_port_sequencer_pkg.sv
// Shared CPU definitions for the register-bank port sequencer: state encoding
// and default operand/index widths.
package regfile_port_sequencer_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int REG_BITS_DEF   = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_READ1 = 3'd2;
  localparam logic [2:0] ST_READ2 = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    WRITE = ST_WRITE,
    READ1 = ST_READ1,
    READ2 = ST_READ2,
    HOLD  = ST_HOLD
  } seq_state_t;

endpackage

// File: rtl/regfile_port_sequencer.sv
// Serialises operand reads (rs1, optional rs2) and writebacks onto the single
// index/strobe port of the CPU register bank.
module regfile_port_sequencer
  import regfile_port_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int REG_BITS   = REG_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic [REG_BITS-1:0]   reqRs1,
  input  logic [REG_BITS-1:0]   reqRs2,
  input  logic                  reqNeedRs2,
  output logic                  opValid,
  input  logic                  opReady,
  output logic [DATA_WIDTH-1:0] rs1Value,
  output logic [DATA_WIDTH-1:0] rs2Value,
  input  logic                  wbValid,
  output logic                  wbReady,
  input  logic [REG_BITS-1:0]   wbRd,
  input  logic [DATA_WIDTH-1:0] wbData,
  output logic [REG_BITS-1:0]   bankRegNum,
  output logic [DATA_WIDTH-1:0] bankDataIn,
  input  logic [DATA_WIDTH-1:0] bankDataOut,
  output logic                  bankWriteEnable
);

  seq_state_t            state_q;
  logic [REG_BITS-1:0]   rs2_idx_q;
  logic                  need_rs2_q;
  logic                  op_valid_q;
  logic [DATA_WIDTH-1:0] rs1_value_q;
  logic [DATA_WIDTH-1:0] rs2_value_q;
  logic [REG_BITS-1:0]   bank_reg_num_q;
  logic [DATA_WIDTH-1:0] bank_data_in_q;
  logic                  bank_we_q;
  logic [DATA_WIDTH-1:0] read_value;

  // Gated by reset so both handshakes read 0 while reset is held.
  assign wbReady  = reset && (state_q == IDLE);
  assign reqReady = wbReady && !wbValid;

  assign opValid         = op_valid_q;
  assign rs1Value        = rs1_value_q;
  assign rs2Value        = rs2_value_q;
  assign bankRegNum      = bank_reg_num_q;
  assign bankDataIn      = bank_data_in_q;
  assign bankWriteEnable = bank_we_q;

  // Index 0 reads as zero whatever the bank returns.
  assign read_value = (bank_reg_num_q == '0) ? '0 : bankDataOut;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      rs2_idx_q      <= '0;
      need_rs2_q     <= 1'b0;
      op_valid_q     <= 1'b0;
      rs1_value_q    <= '0;
      rs2_value_q    <= '0;
      bank_reg_num_q <= '0;
      bank_data_in_q <= '0;
      bank_we_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wbValid) begin
            bank_reg_num_q <= wbRd;
            bank_data_in_q <= wbData;
            bank_we_q      <= 1'b1;
            state_q        <= WRITE;
          end else if (reqValid) begin
            bank_reg_num_q <= reqRs1;
            rs2_idx_q      <= reqRs2;
            need_rs2_q     <= reqNeedRs2;
            state_q        <= READ1;
          end
        end
        WRITE: begin
          bank_reg_num_q <= '0;
          bank_data_in_q <= '0;
          bank_we_q      <= 1'b0;
          state_q        <= IDLE;
        end
        READ1: begin
          rs1_value_q <= read_value;
          if (need_rs2_q) begin
            bank_reg_num_q <= rs2_idx_q;
            state_q        <= READ2;
          end else begin
            bank_reg_num_q <= '0;
            rs2_value_q    <= '0;
            op_valid_q     <= 1'b1;
            state_q        <= HOLD;
          end
        end
        READ2: begin
          rs2_value_q    <= read_value;
          bank_reg_num_q <= '0;
          op_valid_q     <= 1'b1;
          state_q        <= HOLD;
        end
        HOLD: begin
          if (opReady) begin
            op_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          bank_reg_num_q <= '0;
          bank_data_in_q <= '0;
          bank_we_q      <= 1'b0;
          op_valid_q     <= 1'b0;
          state_q        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Directed bench for regfile_port_sequencer: a transaction-level model is
// checked every cycle, and literal expectations pin the directed scenarios.
module tb_regfile_port_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic [3:0]  reqRs1 = '0;
  logic [3:0]  reqRs2 = '0;
  logic        reqNeedRs2 = 1'b0;
  logic        opValid;
  logic        opReady = 1'b0;
  logic [31:0] rs1Value;
  logic [31:0] rs2Value;
  logic        wbValid = 1'b0;
  logic        wbReady;
  logic [3:0]  wbRd = '0;
  logic [31:0] wbData = '0;
  logic [3:0]  bankRegNum;
  logic [31:0] bankDataIn;
  logic [31:0] bankDataOut;
  logic        bankWriteEnable;

  int tests = 0;
  int fails = 0;
  int we_count = 0;
  logic force_ff = 1'b0;

  always #5 clk = ~clk;

  regfile_port_sequencer #(.DATA_WIDTH(32), .REG_BITS(4)) dut (
    .clk(clk), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqRs1(reqRs1), .reqRs2(reqRs2),
    .reqNeedRs2(reqNeedRs2), .opValid(opValid), .opReady(opReady),
    .rs1Value(rs1Value), .rs2Value(rs2Value),
    .wbValid(wbValid), .wbReady(wbReady), .wbRd(wbRd), .wbData(wbData),
    .bankRegNum(bankRegNum), .bankDataIn(bankDataIn), .bankDataOut(bankDataOut),
    .bankWriteEnable(bankWriteEnable)
  );

  // Register bank environment: combinational read, writes to x0 dropped.
  logic [31:0] bank_mem [16];
  initial begin
    for (int i = 0; i < 16; i++) bank_mem[i] = 32'h0;
    bank_mem[0] = 32'hCAFE0000;
  end
  assign bankDataOut = force_ff ? 32'hFFFFFFFF : bank_mem[bankRegNum];
  always @(posedge clk) begin
    if (bankWriteEnable) begin
      we_count <= we_count + 1;
      if (bankRegNum != 4'd0) bank_mem[bankRegNum] <= bankDataIn;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: each accepted transaction schedules the bank
  // port usage it must produce, then (for reads) a hold phase until opReady.
  typedef struct {
    logic [3:0]  num;
    logic [31:0] din;
    logic        we;
    logic        last;
  } slot_t;

  slot_t       sched[$];
  logic        m_hold = 1'b0;
  logic [31:0] m_rs1 = '0;
  logic [31:0] m_rs2 = '0;
  logic [31:0] m_mem [16];
  initial for (int i = 0; i < 16; i++) m_mem[i] = 32'h0;

  function automatic logic [31:0] m_read(input logic [3:0] idx);
    if (idx == 4'd0) return 32'h0;
    if (force_ff) return 32'hFFFFFFFF;
    return m_mem[idx];
  endfunction

  always @(negedge clk) begin
    logic        idle;
    logic [3:0]  e_num;
    logic [31:0] e_din;
    logic        e_we;
    slot_t       s;
    if (!reset) begin
      chk("rst_wbReady", {31'b0, wbReady}, 32'h0);
      chk("rst_reqReady", {31'b0, reqReady}, 32'h0);
      chk("rst_opValid", {31'b0, opValid}, 32'h0);
      chk("rst_bankWE", {31'b0, bankWriteEnable}, 32'h0);
      chk("rst_bankRegNum", {28'b0, bankRegNum}, 32'h0);
      chk("rst_bankDataIn", bankDataIn, 32'h0);
      chk("rst_rs1Value", rs1Value, 32'h0);
      chk("rst_rs2Value", rs2Value, 32'h0);
      sched.delete();
      m_hold = 1'b0;
    end else begin
      idle  = (sched.size() == 0) && !m_hold;
      e_num = '0;
      e_din = '0;
      e_we  = 1'b0;
      if (sched.size() != 0) begin
        e_num = sched[0].num;
        e_din = sched[0].din;
        e_we  = sched[0].we;
      end
      chk("wbReady", {31'b0, wbReady}, {31'b0, idle});
      chk("reqReady", {31'b0, reqReady}, {31'b0, idle && !wbValid});
      chk("opValid", {31'b0, opValid}, {31'b0, m_hold});
      chk("bankWE", {31'b0, bankWriteEnable}, {31'b0, e_we});
      chk("bankRegNum", {28'b0, bankRegNum}, {28'b0, e_num});
      chk("bankDataIn", bankDataIn, e_din);
      if (m_hold) begin
        chk("rs1Value", rs1Value, m_rs1);
        chk("rs2Value", rs2Value, m_rs2);
      end
      // Advance the model across the coming clock edge.
      if (sched.size() != 0) begin
        s = sched.pop_front();
        if (s.we && s.num != 4'd0) m_mem[s.num] = s.din;
        if (s.last) m_hold = 1'b1;
      end else if (m_hold) begin
        if (opReady) m_hold = 1'b0;
      end else if (wbValid) begin
        sched.push_back('{num: wbRd, din: wbData, we: 1'b1, last: 1'b0});
      end else if (reqValid) begin
        m_rs1 = m_read(reqRs1);
        m_rs2 = reqNeedRs2 ? m_read(reqRs2) : 32'h0;
        sched.push_back('{num: reqRs1, din: 32'h0, we: 1'b0, last: !reqNeedRs2});
        if (reqNeedRs2) sched.push_back('{num: reqRs2, din: 32'h0, we: 1'b0, last: 1'b1});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wb(input logic [3:0] rd, input logic [31:0] data);
    int n;
    wbValid = 1'b1;
    wbRd    = rd;
    wbData  = data;
    #1;
    n = 0;
    while (!wbReady && n < 50) begin tick(); n++; end
    if (!wbReady) chk("wb_timeout", 32'h0, 32'h1);
    tick();
    wbValid = 1'b0;
    $display("[TB] writeback rd=%0d data=%h", rd, data);
  endtask

  task automatic do_req(input logic [3:0] rs1, input logic [3:0] rs2, input logic need,
                        input logic [31:0] exp1, input logic [31:0] exp2,
                        input int exp_lat, input int hold_cycles);
    int n;
    reqValid   = 1'b1;
    reqRs1     = rs1;
    reqRs2     = rs2;
    reqNeedRs2 = need;
    #1;
    n = 0;
    while (!reqReady && n < 50) begin tick(); n++; end
    if (!reqReady) chk("req_timeout", 32'h0, 32'h1);
    tick();
    reqValid = 1'b0;
    n = 1;
    while (!opValid && n < 20) begin tick(); n++; end
    chk("latency", n, exp_lat);
    chk("lit_rs1Value", rs1Value, exp1);
    chk("lit_rs2Value", rs2Value, exp2);
    for (int i = 0; i < hold_cycles; i++) begin
      tick();
      chk("hold_opValid", {31'b0, opValid}, 32'h1);
      chk("hold_rs1Value", rs1Value, exp1);
      chk("hold_rs2Value", rs2Value, exp2);
    end
    opReady = 1'b1;
    tick();
    opReady = 1'b0;
    chk("release_opValid", {31'b0, opValid}, 32'h0);
    $display("[TB] read rs1=%0d rs2=%0d need=%0d -> %h %h latency=%0d",
             rs1, rs2, need, rs1Value, rs2Value, n);
  endtask

  initial begin
    int we_before;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("idle_wbReady", {31'b0, wbReady}, 32'h1);
    chk("idle_reqReady", {31'b0, reqReady}, 32'h1);
    chk("idle_opValid", {31'b0, opValid}, 32'h0);

    // Writeback x5, then seed x6 for the two-operand read.
    do_wb(4'd5, 32'hDEADBEEF);
    chk("wr_bankWE", {31'b0, bankWriteEnable}, 32'h1);
    chk("wr_bankRegNum", {28'b0, bankRegNum}, 32'h5);
    chk("wr_bankDataIn", bankDataIn, 32'hDEADBEEF);
    tick();
    chk("wr_done_WE", {31'b0, bankWriteEnable}, 32'h0);
    chk("wr_done_wbReady", {31'b0, wbReady}, 32'h1);
    do_wb(4'd6, 32'h00000012);
    tick();

    do_req(4'd5, 4'd6, 1'b1, 32'hDEADBEEF, 32'h00000012, 3, 4);

    // Simultaneous writeback and read: write must go first.
    wbValid = 1'b1; wbRd = 4'd7; wbData = 32'h55;
    reqValid = 1'b1; reqRs1 = 4'd7; reqRs2 = 4'd3; reqNeedRs2 = 1'b0;
    #1;
    chk("both_reqReady", {31'b0, reqReady}, 32'h0);
    chk("both_wbReady", {31'b0, wbReady}, 32'h1);
    tick();
    wbValid = 1'b0;
    chk("both_bankWE", {31'b0, bankWriteEnable}, 32'h1);
    chk("both_bankRegNum", {28'b0, bankRegNum}, 32'h7);
    $display("[TB] writeback rd=7 data=00000055 (with pending read)");
    do_req(4'd7, 4'd3, 1'b0, 32'h00000055, 32'h0, 2, 1);

    // Index 0 reads zero even when the bank drives all ones.
    force_ff = 1'b1;
    do_req(4'd0, 4'd0, 1'b1, 32'h0, 32'h0, 3, 1);
    force_ff = 1'b0;

    // Reset asserted in the middle of a two-operand read.
    reqValid = 1'b1; reqRs1 = 4'd5; reqRs2 = 4'd6; reqNeedRs2 = 1'b1;
    #1;
    tick();
    reqValid = 1'b0;
    tick();
    chk("r2_bankRegNum", {28'b0, bankRegNum}, 32'h6);
    we_before = we_count;
    reset = 1'b0;
    #1;
    chk("mid_rst_opValid", {31'b0, opValid}, 32'h0);
    chk("mid_rst_bankRegNum", {28'b0, bankRegNum}, 32'h0);
    chk("mid_rst_rs1Value", rs1Value, 32'h0);
    chk("mid_rst_reqReady", {31'b0, reqReady}, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("post_rst_reqReady", {31'b0, reqReady}, 32'h1);
    chk("post_rst_opValid", {31'b0, opValid}, 32'h0);
    repeat (3) tick();
    chk("post_rst_no_strobe", we_count - we_before, 32'h0);
    $display("[TB] reset during READ2 -> idle");

    // Writeback to x0 still strobes once; a read of x0 returns zero.
    we_before = we_count;
    do_wb(4'd0, 32'hAA);
    chk("x0_bankWE", {31'b0, bankWriteEnable}, 32'h1);
    chk("x0_bankRegNum", {28'b0, bankRegNum}, 32'h0);
    chk("x0_bankDataIn", bankDataIn, 32'hAA);
    tick();
    chk("x0_one_pulse", we_count - we_before, 32'h1);
    do_req(4'd0, 4'd5, 1'b0, 32'h0, 32'h0, 2, 0);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_port_sequencer.md
Name: regfile_port_sequencer

Overview:
- Initiator side of the CPU's single-port register bank. The bank exposes one register index, one write strobe and a combinational read.
- Serialises operand reads (rs1, then optional rs2) and writebacks (rd) onto that single port.
- Faces the decode/execute stages with valid/ready handshakes.
- Sits between the control unit and the register bank.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- REG_BITS, 4, register index width (16 registers).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- reqValid  input  1  operand-read request valid.
- reqReady  output  1  sequencer accepts a read request this cycle.
- reqRs1  input  REG_BITS  first source register index.
- reqRs2  input  REG_BITS  second source register index.
- reqNeedRs2  input  1  1 = read rs2 as well; 0 = rs1 only.
- opValid  output  1  rs1Value/rs2Value are valid.
- opReady  input  1  consumer takes the operands.
- rs1Value  output  DATA_WIDTH  rs1 operand.
- rs2Value  output  DATA_WIDTH  rs2 operand; 0 when reqNeedRs2 = 0.
- wbValid  input  1  writeback request valid.
- wbReady  output  1  sequencer accepts the writeback this cycle.
- wbRd  input  REG_BITS  destination register index.
- wbData  input  DATA_WIDTH  writeback value.
- bankRegNum  output  REG_BITS  register bank index.
- bankDataIn  output  DATA_WIDTH  register bank write data.
- bankDataOut  input  DATA_WIDTH  register bank combinational read data.
- bankWriteEnable  output  1  register bank write strobe.

Behaviour:
- States: IDLE, WRITE, READ1, READ2, HOLD. Reset state is IDLE.
- While reset = 0, all outputs are 0, state returns to IDLE immediately, and any pending operands or latched write are discarded.
- Handshakes:
  - wbReady = (state == IDLE).
  - reqReady = (state == IDLE) && !wbValid. Writeback wins over a simultaneous read, so a read issued after a writeback always sees the new value.
  - Both handshakes are combinational on state and wbValid only; they never depend on reqValid or opReady.
- IDLE:
  - bankRegNum = 0, bankWriteEnable = 0, bankDataIn = 0.
  - wbValid (accepted): latch wbRd and wbData, go to WRITE.
  - Else reqValid (accepted): latch rs1, rs2 and needRs2, go to READ1.
- WRITE (1 cycle):
  - bankRegNum = latched rd, bankDataIn = latched data, bankWriteEnable = 1.
  - Go to IDLE. The write is committed at the end of this cycle.
  - rd = 0 is still driven; the bank discards it.
- READ1 (1 cycle):
  - bankRegNum = rs1, bankWriteEnable = 0.
  - Capture bankDataOut into rs1Value at the clock edge.
  - Go to READ2 if needRs2, else HOLD with rs2Value = 0.
- READ2 (1 cycle):
  - bankRegNum = rs2, bankWriteEnable = 0.
  - Capture bankDataOut into rs2Value.
  - Go to HOLD.
- Index 0: a read of index 0 forces the captured value to 0 regardless of bankDataOut. It still costs its cycle, so latency stays fixed.
- HOLD:
  - opValid = 1; rs1Value and rs2Value are held stable.
  - On opReady, go to IDLE. opValid is never withdrawn without opReady.
- Latency from request acceptance to opValid: 2 cycles (rs1 only) or 3 cycles (both). Writeback occupies the port for 1 cycle after acceptance.
- Throughput: at most one transaction in flight. A new request is accepted only in IDLE, at the earliest the cycle after HOLD completes.
- Only WRITE drives bankWriteEnable high, and only for exactly one cycle per accepted writeback.
- rs1Value and rs2Value keep their last captured values outside HOLD; they are not cleared on leaving HOLD.

Decomposition:
- Shared CPU package: state encoding localparams (IDLE=0, WRITE=1, READ1=2, READ2=3, HOLD=4), plus DATA_WIDTH and REG_BITS defaults.
- No sub-module; a single FSM plus operand registers is natural.

Test Plan:
- Reset release, then wbValid with rd=5, data=0xDEADBEEF -> wbReady=1 in IDLE; next cycle bankWriteEnable=1, bankRegNum=5, bankDataIn=0xDEADBEEF; back to IDLE after that.
- Request rs1=5, rs2=6, needRs2=1, with the bank model holding x5=0xDEADBEEF and x6=0x12 -> opValid 3 cycles after acceptance, rs1Value=0xDEADBEEF, rs2Value=0x12; values held while opReady=0 for 4 cycles.
- wbValid and reqValid asserted in the same IDLE cycle (wb rd=7, data=0x55; req rs1=7, needRs2=0) -> reqReady=0 and the write happens first; the read then returns rs1Value=0x55, rs2Value=0.
- Request rs1=0, rs2=0 while the bank model returns 0xFFFFFFFF -> rs1Value=0, rs2Value=0, same 3-cycle latency.
- reset driven to 0 during READ2 -> all outputs 0 immediately; after release, state is IDLE, reqReady=1, opValid=0, no stray write strobe.
- Writeback with rd=0, data=0xAA, then read rs1=0 -> bankWriteEnable pulses once with bankRegNum=0; the read returns 0.
